map_mem_ctrl: RTL

//  Owns the tile-state map that feeds drawcon. Holds one MAP_MEM_WIDTH-bit state per tile (NUM_ROW x NUM_COL,
//  row-major, addr = row*NUM_COL+col) in a dual-port RAM: sync read port for drawcon, arbitrated write port for game logic.

---
 rtl/bomberman_pkg.sv | 49 ++++
 rtl/map_mem_if.sv | 22 ++
 rtl/map_mem_ctrl_lfsr16.sv | 28 ++
 rtl/map_mem_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// Shared map definitions: tile-state encoding, map geometry and layout helpers.
// Used by map_mem_ctrl, drawcon and the game logic.
package bomberman_pkg;

    localparam int unsigned MAP_MEM_WIDTH = 4;
    localparam int unsigned NUM_ROW       = 11;
    localparam int unsigned NUM_COL       = 19;
    localparam int unsigned NUM_BLKS      = NUM_ROW * NUM_COL;
    localparam int unsigned BLK_IND_WIDTH = $clog2(NUM_BLKS);
    localparam int unsigned ROW_WIDTH     = $clog2(NUM_ROW);
    localparam int unsigned COL_WIDTH     = $clog2(NUM_COL);

    typedef enum logic [MAP_MEM_WIDTH-1:0] {
        no_blk          = MAP_MEM_WIDTH'(0),
        perm_blk        = MAP_MEM_WIDTH'(1),
        destroyable_blk = MAP_MEM_WIDTH'(2),
        player          = MAP_MEM_WIDTH'(3),
        enemy           = MAP_MEM_WIDTH'(4),
        bomb            = MAP_MEM_WIDTH'(5),
        explosion       = MAP_MEM_WIDTH'(6),
        power_up        = MAP_MEM_WIDTH'(7),
        border          = MAP_MEM_WIDTH'(8)
    } map_state_t;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } ctrl_state_t;

    // Level layout for one tile; earlier rules win.
    function automatic logic [MAP_MEM_WIDTH-1:0] layout_tile(
        input logic [ROW_WIDTH-1:0] row,
        input logic [COL_WIDTH-1:0] col,
        input logic                 destr
    );
        if (row[0] && col[0])
            return perm_blk;
        if ((row < ROW_WIDTH'(2)) && (col < COL_WIDTH'(2)))
            return no_blk;
        if (destr)
            return destroyable_blk;
        return no_blk;
    endfunction

    function automatic logic [1:0] mod3_inc(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

endpackage

// File: rtl/map_mem_if.sv
// Tile-map access bus: drawcon read port plus game-logic write handshake.
interface map_mem_if;
    import bomberman_pkg::*;

    logic [BLK_IND_WIDTH-1:0] rd_addr;
    logic [MAP_MEM_WIDTH-1:0] rd_data;
    logic                     wr_req;
    logic [BLK_IND_WIDTH-1:0] wr_addr;
    logic [MAP_MEM_WIDTH-1:0] wr_data;
    logic                     wr_ack;
    logic                     init_done;

    modport master (
        output rd_addr, wr_req, wr_addr, wr_data,
        input  rd_data, wr_ack, init_done
    );

    modport slave (
        input  rd_addr, wr_req, wr_addr, wr_data,
        output rd_data, wr_ack, init_done
    );
endinterface

// File: rtl/map_mem_ctrl_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) used for random destroyable tiles.
// Only compiled when RANDOM_DESTR_EN is defined.
`ifdef RANDOM_DESTR_EN
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    logic [15:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (en)
            q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (rst)
            q_q <= seed;
        else
            q_q <= q_d;
    end

    assign q = q_q;
endmodule
`endif

// File: rtl/map_mem_ctrl.sv
// Tile-state map owner: loads the level layout after reset, then serves drawcon reads and game writes.
// RANDOM_DESTR_EN selects LFSR-placed destroyable tiles instead of the (row+col)%3 pattern.
module map_mem_ctrl
    import bomberman_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [7:0]  DESTR_THRESH = 8'd96
) (
    input  logic      clk,
    input  logic      rst,
    map_mem_if.slave  bus
);

    ctrl_state_t              state_q, state_d;
    logic [ROW_WIDTH-1:0]     row_q, row_d;
    logic [COL_WIDTH-1:0]     col_q, col_d;
    logic [BLK_IND_WIDTH-1:0] addr_q, addr_d;
    logic [MAP_MEM_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                     init_done_q, init_done_d;

    logic                     wr_ack_c;
    logic                     mem_we_c;
    logic [BLK_IND_WIDTH-1:0] mem_waddr_c;
    logic [MAP_MEM_WIDTH-1:0] mem_wdata_c;
    logic                     destr_c;

    logic [MAP_MEM_WIDTH-1:0] mem [NUM_BLKS];

`ifdef RANDOM_DESTR_EN
    logic [15:0] lfsr_val;
    logic        unused_lfsr_hi;

    lfsr16 u_lfsr16 (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_INIT),
        .seed (LFSR_SEED),
        .q    (lfsr_val)
    );

    assign destr_c        = (lfsr_val[7:0] < DESTR_THRESH);
    assign unused_lfsr_hi = ^lfsr_val[15:8];
`else
    // (row+col)%3 tracked incrementally: sum for the current tile, row%3 for the next wrap.
    logic [1:0] sum_mod3_q, sum_mod3_d;
    logic [1:0] row_mod3_q, row_mod3_d;
    logic       unused_cfg;

    assign unused_cfg = ^{LFSR_SEED, DESTR_THRESH};
    assign destr_c    = (sum_mod3_q == 2'd0);

    always_comb begin
        sum_mod3_d = sum_mod3_q;
        row_mod3_d = row_mod3_q;
        if (state_q == ST_INIT) begin
            if (col_q == COL_WIDTH'(NUM_COL - 1)) begin
                row_mod3_d = mod3_inc(row_mod3_q);
                sum_mod3_d = mod3_inc(row_mod3_q);
            end else begin
                sum_mod3_d = mod3_inc(sum_mod3_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_mod3_q <= 2'd0;
            row_mod3_q <= 2'd0;
        end else begin
            sum_mod3_q <= sum_mod3_d;
            row_mod3_q <= row_mod3_d;
        end
    end
`endif

    // Sequencer, read port and write arbitration share the single RAM write port.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        addr_d      = addr_q;
        init_done_d = init_done_q;
        rd_data_d   = '0;
        wr_ack_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = addr_q;
        mem_wdata_c = no_blk;

        unique case (state_q)
            ST_INIT: begin
                mem_we_c    = 1'b1;
                mem_wdata_c = layout_tile(row_q, col_q, destr_c);
                if (addr_q == BLK_IND_WIDTH'(NUM_BLKS - 1)) begin
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                    addr_d      = '0;
                    row_d       = '0;
                    col_d       = '0;
                end else begin
                    addr_d = addr_q + BLK_IND_WIDTH'(1);
                    if (col_q == COL_WIDTH'(NUM_COL - 1)) begin
                        col_d = '0;
                        row_d = row_q + ROW_WIDTH'(1);
                    end else begin
                        col_d = col_q + COL_WIDTH'(1);
                    end
                end
            end
            ST_READY: begin
                if (bus.rd_addr < BLK_IND_WIDTH'(NUM_BLKS))
                    rd_data_d = mem[bus.rd_addr];
                wr_ack_c    = bus.wr_req;
                mem_we_c    = bus.wr_req && (bus.wr_addr < BLK_IND_WIDTH'(NUM_BLKS));
                mem_waddr_c = bus.wr_addr;
                mem_wdata_c = bus.wr_data;
            end
            default: ;
        endcase

        // A request seen while reset is asserted is dropped, not acknowledged.
        if (rst) begin
            wr_ack_c = 1'b0;
            mem_we_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            row_q       <= '0;
            col_q       <= '0;
            addr_q      <= '0;
            rd_data_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            addr_q      <= addr_d;
            rd_data_q   <= rd_data_d;
            init_done_q <= init_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c)
            mem[mem_waddr_c] <= mem_wdata_c;
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.init_done = init_done_q;
    assign bus.wr_ack    = wr_ack_c;

endmodule
